// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and helpers for the APB transfer arbiter
//
// Purpose: FSM state type, slave-select bit position and the address-to-slave
//          decode used by apb_xfer_arbiter.
// Ports:   none (package)
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int AW_DEF      = 9;
  localparam int SLV_SEL_BIT = AW_DEF - 1;
  // Widest address the decode helper accepts; callers zero-extend into it.
  localparam int ADDR_MAX    = 32;

  // 0 selects slave 1, 1 selects slave 2.
  function automatic logic slave_of(input logic [ADDR_MAX-1:0] addr,
                                    input int sel_bit = SLV_SEL_BIT);
    return addr[sel_bit];
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin one-hot arbiter
//
// Purpose: picks one of NREQ requesters, starting the search just after the
//          last winner; the pointer moves only when advance is asserted.
// Ports:
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous reset, active-low (requester 0 wins first)
//   req      in   NREQ request vector
//   advance  in   grant is taken this cycle; remember the winner
//   grant    out  NREQ one-hot grant (combinational, 0 when no request)
module apb_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] last_q, last_d;

  // Search in circular order from last_q+1 so the last winner is checked last.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(last_q) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) last_d = PW'(i);
      end
    end
  end

  // Reset to the highest index so requester 0 has top priority first.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) last_q <= PW'(NREQ - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/apb_xfer_arbiter.sv
// rtl/apb_xfer_arbiter.sv - shares one APB master port between NREQ requesters
//
// Purpose: round-robin arbitration, APB IDLE->SETUP->ACCESS sequencing, decode
//          to two slaves on paddr[AW-1], response return to the winner.
// Option:  APB_TIMEOUT_EN adds an ACCESS-phase watchdog of TIMEOUT_CYC cycles.
// Ports:
//   pclk, presetn              clock / asynchronous active-low reset
//   req_valid/write/addr/wdata requester side, packed per requester
//   req_grant                  one-hot pulse when a request is captured
//   rsp_valid/rdata/err        one-hot completion pulse, read data, error
//   psel1/psel2/penable/pwrite/paddr/pwdata   APB master outputs
//   prdata1/2, pready1/2, pslverr             APB slave returns
module apb_xfer_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = AW_DEF,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_grant,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel1,
  output logic               psel2,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata1,
  input  logic [DW-1:0]      prdata2,
  input  logic               pready1,
  input  logic               pready2,
  input  logic               pslverr
);

  apb_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            write_q, write_d;
  logic [NREQ-1:0] owner_q, owner_d;

  logic [NREQ-1:0] arb_grant;
  logic            slv2;
  logic            sel_ready;
  logic [DW-1:0]   sel_prdata;
  logic            timeout_hit;
  logic            done;
  logic            grant_en;

  assign slv2       = slave_of(ADDR_MAX'(addr_q), AW - 1);
  assign sel_ready  = slv2 ? pready2 : pready1;
  assign sel_prdata = slv2 ? prdata2 : prdata1;

  assign done = (state_q == ACCESS) && (sel_ready || timeout_hit);

  // A new request can be taken from IDLE or in the completing ACCESS cycle
  // (back-to-back). presetn gates the grant so it stays 0 while in reset.
  assign grant_en = ((state_q == IDLE) || done) && (|req_valid) && presetn;

  apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req_valid),
    .advance (grant_en),
    .grant   (arb_grant)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // tmo_cnt_q holds the number of ACCESS cycles already spent without pready.
  assign timeout_hit = (state_q == ACCESS) && !sel_ready &&
                       (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (grant_en)                tmo_cnt_d = '0;
    else if (state_q == ACCESS)  tmo_cnt_d = tmo_cnt_q + CW'(1);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_en) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = grant_en ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    psel1     = 1'b0;
    psel2     = 1'b0;
    penable   = 1'b0;
    req_grant = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if ((state_q == SETUP) || (state_q == ACCESS)) begin
      psel1 = !slv2;
      psel2 = slv2;
    end
    penable = (state_q == ACCESS);
    if (grant_en) req_grant = arb_grant;
    if (done) begin
      rsp_valid = owner_q;
      rsp_err   = timeout_hit || pslverr;
      rsp_rdata = (write_q || timeout_hit) ? '0 : sel_prdata;
    end
  end

  // Request capture; values hold until the next grant.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    owner_d = owner_q;
    if (grant_en) begin
      owner_d = arb_grant;
      for (int i = 0; i < NREQ; i++) begin
        if (arb_grant[i]) begin
          addr_d  = req_addr[i*AW +: AW];
          wdata_d = req_wdata[i*DW +: DW];
          write_d = req_write[i];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      owner_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      owner_q <= owner_d;
    end
  end

  assign paddr  = addr_q;
  assign pwdata = wdata_q;
  assign pwrite = write_q;

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// tb/tb_apb_xfer_arbiter.sv - self-checking bench for apb_xfer_arbiter
module tb_apb_xfer_arbiter;

  localparam int NREQ = 3;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TIMEOUT_CYC = 16;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req_valid, req_write, req_grant, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, pwdata, prdata1, prdata2;
  logic               rsp_err, psel1, psel2, penable, pwrite, pready1, pready2, pslverr;
  logic [AW-1:0]      paddr;

  int checks = 0;
  int errors = 0;

  apb_xfer_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata1(prdata1), .prdata2(prdata2), .pready1(pready1), .pready2(pready2), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata1 = '0; prdata2 = '0; pready1 = 1'b0; pready2 = 1'b0; pslverr = 1'b0;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1; req_write[r] = wr;
    req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = d;
  endtask

  // Inputs are driven just after the falling edge; outputs sampled 1 time unit later.
  task automatic step();
    @(negedge pclk);
  endtask

  task automatic test_reset();
    idle_inputs();
    presetn = 1'b0;
    set_req(0, 1'b1, 9'h1AB, 8'h5A); set_req(2, 1'b0, 9'h101, 8'h00);
    pready1 = 1'b1; pready2 = 1'b1; pslverr = 1'b1; prdata1 = 8'hFF; prdata2 = 8'hFF;
    step(); #1;
    checks++; if ({req_grant, rsp_valid, psel1, psel2, penable, pwrite, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {req_grant, rsp_valid, psel1, psel2, penable, pwrite, rsp_err}); end
    checks++; if ({paddr, pwdata, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {paddr, pwdata, rsp_rdata}); end
    step(); idle_inputs(); presetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      checks++; if ({psel1, psel2, penable, req_grant, rsp_valid} !== '0) begin
        errors++; $display("FAIL reset_idle cyc %0d got %b exp 0", i, {psel1, psel2, penable, req_grant, rsp_valid}); end
    end
  endtask

  task automatic test_single_write();
    step(); idle_inputs(); set_req(0, 1'b1, 9'h005, 8'hA5); pready1 = 1'b1; #1;
    checks++; if (req_grant !== 3'b001) begin errors++; $display("FAIL wr_grant got %b exp 001", req_grant); end
    step(); req_valid = '0; #1;
    checks++; if ({psel1, psel2, penable} !== 3'b100) begin errors++; $display("FAIL wr_setup got %b exp 100", {psel1, psel2, penable}); end
    checks++; if ({paddr, pwrite, pwdata} !== {9'h005, 1'b1, 8'hA5}) begin
      errors++; $display("FAIL wr_bus got %h exp %h", {paddr, pwrite, pwdata}, {9'h005, 1'b1, 8'hA5}); end
    step(); #1;
    checks++; if ({psel1, penable, rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 3'b001, 1'b0, 8'h00}) begin
      errors++; $display("FAIL wr_access got %h exp %h", {psel1, penable, rsp_valid, rsp_err, rsp_rdata}, {2'b11, 3'b001, 1'b0, 8'h00}); end
    step(); #1;
    checks++; if ({psel1, penable, rsp_valid, paddr} !== {2'b00, 3'b000, 9'h005}) begin
      errors++; $display("FAIL wr_idle_hold got %h exp %h", {psel1, penable, rsp_valid, paddr}, {2'b00, 3'b000, 9'h005}); end
  endtask

  task automatic test_read_slave2();
    step(); idle_inputs(); set_req(1, 1'b0, 9'h105, 8'h00); #1;
    checks++; if (req_grant !== 3'b010) begin errors++; $display("FAIL rd_grant got %b exp 010", req_grant); end
    for (int i = 0; i < 5; i++) begin
      step(); req_valid = '0; prdata2 = 8'h3C; pready2 = (i == 4); pready1 = 1'b1; prdata1 = 8'hEE; #1;
      checks++; if ({psel1, psel2, penable, rsp_valid} !== {2'b01, (i > 0), (i == 4) ? 3'b010 : 3'b000}) begin
        errors++; $display("FAIL rd_phase cyc %0d got %b exp %b", i, {psel1, psel2, penable, rsp_valid}, {2'b01, (i > 0), (i == 4) ? 3'b010 : 3'b000}); end
    end
    checks++; if ({rsp_rdata, rsp_err, paddr, pwrite} !== {8'h3C, 1'b0, 9'h105, 1'b0}) begin
      errors++; $display("FAIL rd_data got %h exp %h", {rsp_rdata, rsp_err, paddr, pwrite}, {8'h3C, 1'b0, 9'h105, 1'b0}); end
    step(); idle_inputs(); #1;
    checks++; if ({psel1, psel2, penable} !== 3'b000) begin errors++; $display("FAIL rd_end got %b exp 000", {psel1, psel2, penable}); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] eg, er;
    logic [2:0]      ectl;
    for (int c = 0; c <= 8; c++) begin
      step(); idle_inputs(); pready1 = 1'b1; prdata1 = 8'h5A;
      if (c < 8) begin set_req(0, 1'b1, 9'h011, 8'h10); set_req(1, 1'b0, 9'h022, 8'h20); end
      eg = ((c % 2) == 0 && c < 8) ? NREQ'(1 << ((c / 2) % 2)) : '0;
      er = ((c % 2) == 0 && c > 0) ? NREQ'(1 << (((c / 2) - 1) % 2)) : '0;
      ectl = (c % 2) == 1 ? 3'b100 : (c > 0 ? 3'b101 : 3'b000);
      #1;
      checks++; if ({req_grant, rsp_valid, psel1, psel2, penable} !== {eg, er, ectl}) begin
        errors++; $display("FAIL b2b cyc %0d got %b exp %b", c, {req_grant, rsp_valid, psel1, psel2, penable}, {eg, er, ectl}); end
      if (c % 2 == 1) begin
        checks++; if (paddr !== ((c % 4) == 1 ? 9'h011 : 9'h022)) begin
          errors++; $display("FAIL b2b_addr cyc %0d got %h exp %h", c, paddr, (c % 4) == 1 ? 9'h011 : 9'h022); end
      end
    end
  endtask

  task automatic test_slave_error();
    for (int n = 0; n < 2; n++) begin
      step(); idle_inputs(); set_req(0, 1'b1, 9'h010, 8'hEE); #1;
      checks++; if (req_grant !== 3'b001) begin errors++; $display("FAIL err_grant %0d got %b exp 001", n, req_grant); end
      step(); req_valid = '0; pslverr = 1'b1; #1;
      checks++; if ({rsp_valid, rsp_err} !== 4'b0000) begin errors++; $display("FAIL err_setup %0d got %b exp 0000", n, {rsp_valid, rsp_err}); end
      step(); pready1 = 1'b1; pslverr = (n == 0); #1;
      checks++; if ({rsp_valid, rsp_err} !== {3'b001, (n == 0)}) begin
        errors++; $display("FAIL err_rsp %0d got %b exp %b", n, {rsp_valid, rsp_err}, {3'b001, (n == 0)}); end
    end
    step(); idle_inputs();
  endtask

  // Reference model: requesters hold requests until granted; the slave inserts a
  // random number of wait states. Expected bus activity follows the timeline
  // grant -> one setup cycle -> (waits+1) access cycles, response on the last.
  task automatic test_random();
    logic [NREQ-1:0] pend, exp_g, exp_r;
    logic [AW-1:0]   ra [NREQ];
    logic [DW-1:0]   rd [NREQ];
    logic            rw [NREQ];
    logic [AW-1:0]   cur_a;
    logic [DW-1:0]   cur_d, rdv, exp_rd;
    logic            cur_w, cur_e, cur_s2, busy, fin;
    int              last, t, waits, owner, win, idx;
    idle_inputs(); presetn = 1'b0; step(); presetn = 1'b1;
    pend = '0; last = NREQ - 1; busy = 1'b0; t = 0; waits = 0; owner = 0;
    cur_a = '0; cur_d = '0; cur_w = 1'b0; cur_e = 1'b0; cur_s2 = 1'b0; rdv = '0;
    for (int r = 0; r < NREQ; r++) begin ra[r] = '0; rd[r] = '0; rw[r] = 1'b0; end
    for (int c = 0; c < 600; c++) begin
      step();
      for (int r = 0; r < NREQ; r++) begin
        if (!pend[r] && c < 560 && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1; ra[r] = AW'($urandom); rd[r] = DW'($urandom); rw[r] = 1'($urandom);
        end else if (pend[r] && $urandom_range(0, 15) == 0) begin
          pend[r] = 1'b0;
        end
        req_valid[r] = pend[r]; req_write[r] = rw[r];
        req_addr[r*AW +: AW] = ra[r]; req_wdata[r*DW +: DW] = rd[r];
      end
      fin = busy && (t == waits + 2);
      pready1 = 1'($urandom); pready2 = 1'($urandom); pslverr = 1'($urandom);
      prdata1 = DW'($urandom); prdata2 = DW'($urandom);
      if (busy && t >= 2) begin
        if (cur_s2) begin pready2 = fin; if (fin) prdata2 = rdv; end
        else        begin pready1 = fin; if (fin) prdata1 = rdv; end
        if (fin) pslverr = cur_e;
      end
      exp_r = fin ? NREQ'(1 << owner) : '0;
      exp_rd = (fin && !cur_w) ? rdv : '0;
      exp_g = '0; win = -1;
      if ((!busy || fin) && pend != '0) begin
        for (int k = 1; k <= NREQ && win < 0; k++) begin
          idx = (last + k) % NREQ;
          if (pend[idx]) win = idx;
        end
        exp_g = NREQ'(1 << win);
      end
      #1;
      checks++; if (req_grant !== exp_g) begin errors++; $display("FAIL rnd_grant cyc %0d got %b exp %b", c, req_grant, exp_g); end
      checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b exp %b", c, rsp_valid, exp_r); end
      checks++; if ({psel1, psel2, penable} !== {busy && !cur_s2, busy && cur_s2, busy && t >= 2}) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", c, {psel1, psel2, penable}, {busy && !cur_s2, busy && cur_s2, busy && t >= 2}); end
      checks++; if ({paddr, pwrite, pwdata} !== {cur_a, cur_w, cur_d}) begin
        errors++; $display("FAIL rnd_bus cyc %0d got %h exp %h", c, {paddr, pwrite, pwdata}, {cur_a, cur_w, cur_d}); end
      checks++; if ({rsp_rdata, rsp_err} !== {exp_rd, fin && cur_e}) begin
        errors++; $display("FAIL rnd_rsp cyc %0d got %h exp %h", c, {rsp_rdata, rsp_err}, {exp_rd, fin && cur_e}); end
      if (fin) busy = 1'b0;
      else if (busy) t++;
      if (win >= 0) begin
        busy = 1'b1; t = 1; owner = win; last = win; pend[win] = 1'b0;
        cur_a = ra[win]; cur_d = rd[win]; cur_w = rw[win]; cur_s2 = cur_a[AW-1];
        waits = $urandom_range(0, 3); cur_e = 1'($urandom); rdv = DW'($urandom);
      end
    end
    step(); idle_inputs();
  endtask

  task automatic test_mid_reset();
    step(); idle_inputs(); set_req(1, 1'b0, 9'h0F0, 8'h00); prdata1 = 8'h99; #1;
    checks++; if (req_grant !== 3'b010) begin errors++; $display("FAIL mrst_grant got %b exp 010", req_grant); end
    step(); req_valid = '0;
    step(); #1;
    checks++; if ({psel1, penable} !== 2'b11) begin errors++; $display("FAIL mrst_access got %b exp 11", {psel1, penable}); end
    #1; req_valid[0] = 1'b1; presetn = 1'b0; #1;
    checks++; if ({req_grant, rsp_valid, psel1, psel2, penable, pwrite, rsp_err, paddr, pwdata, rsp_rdata} !== '0) begin
      errors++; $display("FAIL mrst_async got %h exp 0", {req_grant, rsp_valid, psel1, psel2, penable, pwrite, rsp_err, paddr, pwdata, rsp_rdata}); end
    step(); pready1 = 1'b1; #1;
    checks++; if ({req_grant, rsp_valid, psel1, penable} !== '0) begin
      errors++; $display("FAIL mrst_held got %b exp 0", {req_grant, rsp_valid, psel1, penable}); end
    step(); presetn = 1'b1; pready1 = 1'b0; set_req(0, 1'b0, 9'h033, 8'h00); set_req(1, 1'b0, 9'h044, 8'h00); #1;
    checks++; if ({req_grant, rsp_valid} !== {3'b001, 3'b000}) begin
      errors++; $display("FAIL mrst_rr_restart got %b exp 001000", {req_grant, rsp_valid}); end
    step(); idle_inputs();
    step(); pready1 = 1'b1; prdata1 = 8'h42; #1;
    checks++; if ({rsp_valid, rsp_rdata} !== {3'b001, 8'h42}) begin
      errors++; $display("FAIL mrst_after got %h exp %h", {rsp_valid, rsp_rdata}, {3'b001, 8'h42}); end
    step(); idle_inputs();
  endtask

  task automatic test_access_limit();
    step(); idle_inputs(); set_req(0, 1'b0, 9'h020, 8'h00); prdata1 = 8'h77; #1;
    checks++; if (req_grant !== 3'b001) begin errors++; $display("FAIL lim_grant got %b exp 001", req_grant); end
    step(); req_valid = '0;
`ifdef APB_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      step(); #1;
      checks++; if (rsp_valid !== ((i == TIMEOUT_CYC) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL tmo_rsp cyc %0d got %b", i, rsp_valid); end
    end
    checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL tmo_err got %h exp %h", {rsp_err, rsp_rdata}, {1'b1, 8'h00}); end
    step(); #1;
    checks++; if ({psel1, penable} !== 2'b00) begin errors++; $display("FAIL tmo_drop got %b exp 00", {psel1, penable}); end
`else
    for (int i = 1; i <= 2 * TIMEOUT_CYC; i++) begin
      step(); #1;
      checks++; if ({psel1, penable, rsp_valid} !== {2'b11, 3'b000}) begin
        errors++; $display("FAIL wait_hold cyc %0d got %b exp 11000", i, {psel1, penable, rsp_valid}); end
    end
    step(); pready1 = 1'b1; #1;
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 8'h77}) begin
      errors++; $display("FAIL wait_done got %h exp %h", {rsp_valid, rsp_err, rsp_rdata}, {3'b001, 1'b0, 8'h77}); end
`endif
    step(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    presetn = 1'b0;
    test_reset();
    test_single_write();
    test_read_slave2();
    test_contention();
    test_slave_error();
    test_random();
    test_mid_reset();
    test_access_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
